// File: rtl/atmega_usb2uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// atmega_usb2uart_rx_fifo
//
// Single-clock byte FIFO in the 48 MHz USB domain. Buffers the received-byte
// stream coming out of the CDC core so that host bursts are absorbed while the
// CPU is slow to read UDR. Provides flush, fill level and empty/full status
// for the UART register block.
//
// Optional feature: define ATMEGA_USB2UART_RX_FIFO_PEAK_EN to add peak_o, the
// highest fill level reached since the last reset or flush.
//
// Ports:
//   clk_i        clock (USB domain)
//   rst_i        synchronous active-high reset (clears pointers, not storage)
//   flush_i      discard all content (pulse or level); blocks pushes
//   in_valid_i   upstream byte valid
//   in_data_i    upstream byte
//   in_accept_o  FIFO takes the byte this cycle
//   out_valid_o  head byte available
//   out_data_o   head byte (asynchronous read, valid only with out_valid_o)
//   out_accept_i downstream pops the head this cycle
//   level_o      number of stored bytes, 0..DEPTH
//   empty_o      level_o == 0
//   full_o       level_o == DEPTH
//   peak_o       (PEAK_EN only) highest level since reset/flush
// -----------------------------------------------------------------------------
module atmega_usb2uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_W-1:0]     in_data_i,
  output logic                  in_accept_o,
  output logic                  out_valid_o,
  output logic [DATA_W-1:0]     out_data_o,
  input  logic                  out_accept_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
  ,
  output logic [DEPTH_LOG2:0]   peak_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [DEPTH_LOG2:0] wp_q, wp_d;
  logic [DEPTH_LOG2:0] rp_q, rp_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic push;
  logic pop;
  logic clear;

  // Status is derived from registered pointers only, so none of it depends on
  // the current-cycle handshakes (no out_accept_i -> in_accept_o path).
  assign level_o     = wp_q - rp_q;
  assign empty_o     = (wp_q == rp_q);
  assign full_o      = (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]) &&
                       (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]);
  assign in_accept_o = ~full_o & ~flush_i;
  assign out_valid_o = ~empty_o;
  assign out_data_o  = mem_q[rp_q[DEPTH_LOG2-1:0]];

  assign clear = rst_i | flush_i;
  assign push  = in_valid_i & in_accept_o;
  assign pop   = out_valid_o & out_accept_i;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (clear) begin
      // Flush/reset wins over any pop presented in the same cycle.
      wp_d = '0;
      rp_d = '0;
    end else begin
      wp_d = wp_q + {{DEPTH_LOG2{1'b0}}, push};
      rp_d = rp_q + {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wp_q[DEPTH_LOG2-1:0]] <= in_data_i;
    end
  end

`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
  logic [DEPTH_LOG2:0] peak_q, peak_d;

  // Tracks the level one cycle behind: the level after an edge is folded
  // into the peak at the following edge.
  always_comb begin
    peak_d = peak_q;
    if (level_o > peak_q) begin
      peak_d = level_o;
    end
    if (clear) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_atmega_usb2uart_rx_fifo.sv
module tb_atmega_usb2uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_accept_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_accept_i = 1'b0;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;
`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
  logic [4:0] peak_o;
`endif

  always #5 clk = ~clk;

  atmega_usb2uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_accept_o  (in_accept_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_accept_i (out_accept_i),
    .level_o      (level_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
    ,
    .peak_o       (peak_o)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of stored bytes plus a peak tracker.
  logic [7:0] model[$];
  int         m_peak = 0;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       oa;
    logic       acc;
    logic       vld;
    logic [4:0] lvl;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model,
  // clock, then advance the model with the queue semantics of the FIFO.
  task automatic step(input logic fl, input logic iv, input logic [7:0] d, input logic oa);
    int  sz;
    bit  do_push, do_pop;
    flush_i      = fl;
    in_valid_i   = iv;
    in_data_i    = d;
    out_accept_i = oa;
    #1;
    sz = model.size();
    chk("in_accept", in_accept_o, (sz < DEPTH) && !fl);
    chk("out_valid", out_valid_o, sz != 0);
    if (sz != 0) chk("out_data", out_data_o, model[0]);
    chk("level", level_o, sz);
    chk("empty", empty_o, sz == 0);
    chk("full", full_o, sz == DEPTH);
`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
    chk("peak", peak_o, m_peak);
`endif
    @(posedge clk);
    if (fl) begin
      model.delete();
      m_peak = 0;
    end else begin
      if (sz > m_peak) m_peak = sz;
      do_push = iv && (sz < DEPTH);
      do_pop  = oa && (sz > 0);
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 5'd1, 8'h11};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd2, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 5'd1, 8'h22};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd1, 8'h33};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd1, 8'h33};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
    tbl[8] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 5'd1, 8'h44};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};

    // Reset held for two cycles, then idle.
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model.delete();
    m_peak = 0;
    #1;
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_accept", in_accept_o, 1);
    chk("rst_full", full_o, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Table-driven vectors from the empty state.
    for (int k = 0; k < 10; k++) begin
      flush_i = tbl[k].fl; in_valid_i = tbl[k].iv;
      in_data_i = tbl[k].d; out_accept_i = tbl[k].oa;
      #1;
      chk($sformatf("tbl%0d_accept", k), in_accept_o, tbl[k].acc);
      chk($sformatf("tbl%0d_valid", k), out_valid_o, tbl[k].vld);
      chk($sformatf("tbl%0d_level", k), level_o, tbl[k].lvl);
      if (tbl[k].vld) chk($sformatf("tbl%0d_data", k), out_data_o, tbl[k].dat);
      step(tbl[k].fl, tbl[k].iv, tbl[k].d, tbl[k].oa);
    end

    // Fill and drain.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("fill_full", full_o, 1);
    chk("fill_accept", in_accept_o, 0);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    chk("fill_level_held", level_o, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", out_data_o, i);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", empty_o, 1);

    // Simultaneous push/pop at level 5, crossing the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("stream_data", out_data_o, (i < 5) ? (8'h50 + i) : (8'h60 + i - 5));
      step(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
      chk("stream_level", level_o, 5);
    end

    // Full boundary: pop while full does not open the input that cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("fullb_level_after_pop", level_o, 15);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    chk("fullb_level_refill", level_o, 16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fullb_empty", empty_o, 1);

    // Flush mid-stream at level 9.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("flush_level", level_o, 0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    chk("flush_next_valid", out_valid_o, 1);
    chk("flush_next_data", out_data_o, 8'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1);

`ifdef ATMEGA_USB2UART_RX_FIFO_PEAK_EN
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("peak_seven", peak_o, 7);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("peak_flush", peak_o, 0);
`endif

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int  pv, pa;
      logic fl;
      pv = ((i / 300) % 2 == 0) ? 85 : 30;
      pa = ((i / 300) % 2 == 0) ? 30 : 85;
      fl = ($urandom_range(0, 199) == 0);
      step(fl, $urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/atmega_usb2uart_rx_fifo.md
# atmega_usb2uart_rx_fifo

Single-clock byte FIFO in the 48 MHz USB domain. It sits directly downstream of the CDC core's received-byte stream (`tx_valid_o` / `tx_data_o` / `tx_accept_i`) and directly upstream of the RX dual-frequency bus adapter in `atmega_usb2uart`. It absorbs host bursts while the CPU is slow to read UDR, so the CDC core is not back-pressured one byte at a time. It also provides flush, level and status outputs for the UART register block.

## Interface
- `DEPTH_LOG2`, default 4: log2 of entry count; DEPTH = 2^DEPTH_LOG2 (16). Legal range 2..8.
- `DATA_W`, default 8: stored word width.
- `clk_i` input 1: clock (48 MHz USB domain).
- `rst_i` input 1: reset; one clock, synchronous, active-high.
- `flush_i` input 1: discard all content; single-cycle pulse or level.
- `in_valid_i` input 1: upstream byte valid (from CDC `tx_valid_o`).
- `in_data_i` input DATA_W: upstream byte.
- `in_accept_o` output 1: FIFO takes the byte this cycle (to CDC `tx_accept_i`).
- `out_valid_o` output 1: head byte available.
- `out_data_o` output DATA_W: head byte.
- `out_accept_i` input 1: downstream pops the head this cycle.
- `level_o` output DEPTH_LOG2+1: number of stored bytes, 0..DEPTH.
- `empty_o` output 1: level_o == 0.
- `full_o` output 1: level_o == DEPTH.

## Operation
- Storage is a DEPTH x DATA_W array with write pointer `wp` and read pointer `rp`, each DEPTH_LOG2+1 bits wide. The extra MSB distinguishes full from empty.
  - empty: `wp == rp`.
  - full: the low bits are equal and the MSBs differ.
- Push: `in_valid_i & in_accept_o`. The byte is written at `wp[DEPTH_LOG2-1:0]`, then `wp` increments and wraps modulo 2^(DEPTH_LOG2+1).
- Pop: `out_valid_o & out_accept_i`. `rp` increments with the same wrap rule. `out_accept_i` while `out_valid_o` = 0 is ignored.
- `in_accept_o = ~full_o & ~flush_i` (combinational). `out_valid_o = ~empty_o`.
- `out_data_o` is an asynchronous read of the entry at `rp[DEPTH_LOG2-1:0]`. It is meaningful only while `out_valid_o` = 1.
- Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Level never exceeds DEPTH and never underflows.
- Flush: on any cycle with `flush_i` = 1, `wp` and `rp` are cleared to 0. Flush has priority over push and pop.
  - No push occurs, because `in_accept_o` = 0.
  - A pop presented in the same cycle has no effect beyond the clear.
- Reset: identical to flush; array contents are not cleared.
- Byte order is strict FIFO. No byte is dropped except by flush or reset.

## Timing
- Reset values: `in_accept_o` = 1 (0 while `flush_i` is high), `out_valid_o` = 0, `empty_o` = 1, `full_o` = 0, `level_o` = 0. `out_data_o` is don't-care.
- Write-to-read latency is 1 cycle. A byte pushed at edge N has `out_valid_o` = 1 and its data on `out_data_o` after edge N.
- No same-cycle fall-through: a push into an empty FIFO is never visible in the same cycle.
- Full boundary: while full, `in_accept_o` = 0 even if a pop occurs in the same cycle. There is no combinational path from `out_accept_i` to `in_accept_o`. The slot freed by the pop is accepted on the next cycle.
- Empty boundary: push-only in a cycle where `out_valid_o` = 0. Level becomes 1 next cycle.
- Throughput: 1 byte per cycle sustained on both sides when neither full nor empty.
- `level_o`, `empty_o` and `full_o` reflect the pointers after the last clock edge. They do not depend on the current-cycle handshakes.

## Configuration
- `ATMEGA_USB2UART_RX_FIFO_PEAK_EN` defined:
  - Adds output `peak_o` [DEPTH_LOG2:0], the highest `level_o` reached since reset or flush.
  - Updated the cycle after each level change: `peak <= max(peak, new level)`.
  - Cleared to 0 by `rst_i` or `flush_i`.
- Macro undefined: `peak_o` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset then idle: `rst_i` high for 2 cycles → `level_o` = 0, `empty_o` = 1, `out_valid_o` = 0, `in_accept_o` = 1.
- Fill and drain: push 0x00..0x0F back-to-back with `out_accept_i` = 0 → `full_o` = 1 and `in_accept_o` = 0 after the 16th push, 17th byte 0x10 held off. Then pop 16 → 0x00..0x0F in order, `empty_o` = 1.
- Simultaneous push/pop at level 5 for 20 cycles → `level_o` stays 5, output sequence equals input sequence delayed by 5 entries, pointer wrap crossed without error.
- Full boundary: at level 16, assert `in_valid_i` (0xA5) and `out_accept_i` together → pop occurs, 0xA5 not accepted that cycle; accepted the next cycle; `level_o` back to 16.
- Flush mid-stream at level 9 with `in_valid_i` = 1 → `in_accept_o` = 0 that cycle, `level_o` = 0 next cycle. Next pushed byte 0x3C appears first at `out_data_o`.
- With the peak macro defined: push 7, pop 4, push 2 → `peak_o` = 7. Flush → `peak_o` = 0.
